// File: rtl/lcd_pkg.sv
// ============================================================================
// lcd_pkg : shared types and constants for the LCD channel mux.  Rev 1.0
// ============================================================================
`default_nettype none

package lcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHOW  = 2'd2
  } lcd_state_t;

  localparam logic [7:0] SPACE_CHAR = 8'h20;
  localparam int         DISP_NUM_W = 6;

endpackage

`default_nettype wire

// File: rtl/lcd_chan_regfile.sv
// ============================================================================
// lcd_chan_regfile : name/value storage, host and capture write ports, one
// combinational read port.  Rev 1.0
// ============================================================================
`default_nettype none

module lcd_chan_regfile
  import lcd_pkg::*;
#(
  parameter int NUM_CH  = 8,
  parameter int NAME_W  = 40,
  parameter int VALUE_W = 32,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               host_we,
  input  logic [CH_W-1:0]    host_ch,
  input  logic               host_name_en,
  input  logic [NAME_W-1:0]  host_name,
  input  logic [VALUE_W-1:0] host_value,
  input  logic               cap_we,
  input  logic [CH_W-1:0]    cap_ch,
  input  logic [VALUE_W-1:0] cap_value,
  input  logic [CH_W-1:0]    rd_ch,
  output logic [NAME_W-1:0]  rd_name,
  output logic [VALUE_W-1:0] rd_value
);

  logic [NAME_W-1:0]  name_q  [NUM_CH];
  logic [VALUE_W-1:0] value_q [NUM_CH];

  // Channels at or above NUM_CH never match an entry, so such writes drop out.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        name_q[i]  <= {(NAME_W/8){SPACE_CHAR}};
        value_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (host_we && (host_ch == CH_W'(i))) begin
          if (host_name_en) name_q[i] <= host_name;
          value_q[i] <= host_value;
        end else if (cap_we && (cap_ch == CH_W'(i))) begin
          value_q[i] <= cap_value;
        end
      end
    end
  end

  assign rd_name  = name_q[rd_ch];
  assign rd_value = value_q[rd_ch];

endmodule

`default_nettype wire

// File: rtl/lcd_channel_mux.sv
// ============================================================================
// lcd_channel_mux : presents the channel selected by display_number to
// lcd_module and captures touch input into a channel.  Rev 1.0
// ============================================================================
`default_nettype none

module lcd_channel_mux
  import lcd_pkg::*;
#(
  parameter int NUM_CH    = 8,
  parameter int BASE_SLOT = 1,
  parameter int NAME_W    = 40,
  parameter int VALUE_W   = 32,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr_en,
  input  logic [CH_W-1:0]       wr_ch,
  input  logic                  wr_name_en,
  input  logic [NAME_W-1:0]     wr_name,
  input  logic [VALUE_W-1:0]    wr_value,
  input  logic                  cap_en,
  input  logic [CH_W-1:0]       cap_ch,
  output logic                  cap_valid,
  output logic [VALUE_W-1:0]    cap_value,
  input  logic [DISP_NUM_W-1:0] display_number,
  input  logic                  input_valid,
  input  logic [31:0]           input_value,
  output logic                  display_valid,
  output logic [NAME_W-1:0]     display_name,
  output logic [VALUE_W-1:0]    display_value
);

  lcd_state_t         state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic               in_range;
  logic [CH_W-1:0]    slot_ch;
  logic [VALUE_W-1:0] touch_value;
  logic [NAME_W-1:0]  rd_name;
  logic [VALUE_W-1:0] rd_value;

  assign in_range    = (int'(display_number) >= BASE_SLOT) &&
                       (int'(display_number) < BASE_SLOT + NUM_CH);
  assign slot_ch     = CH_W'(display_number - DISP_NUM_W'(BASE_SLOT));
  assign touch_value = VALUE_W'(input_value);

  lcd_chan_regfile #(
    .NUM_CH  (NUM_CH),
    .NAME_W  (NAME_W),
    .VALUE_W (VALUE_W)
  ) u_regfile (
    .clk          (clk),
    .resetn       (resetn),
    .host_we      (wr_en),
    .host_ch      (wr_ch),
    .host_name_en (wr_name_en),
    .host_name    (wr_name),
    .host_value   (wr_value),
    .cap_we       (input_valid && cap_en),
    .cap_ch       (cap_ch),
    .cap_value    (touch_value),
    .rd_ch        (ch_q),
    .rd_name      (rd_name),
    .rd_value     (rd_value)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

  // FETCH only advances to SHOW when the slot held still for the whole fetch.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    case (state_q)
      ST_IDLE: begin
        if (in_range) begin
          ch_d    = slot_ch;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (!in_range) begin
          state_d = ST_IDLE;
        end else begin
          ch_d    = slot_ch;
          state_d = (slot_ch == ch_q) ? ST_SHOW : ST_FETCH;
        end
      end
      ST_SHOW: begin
        if (!in_range) begin
          state_d = ST_IDLE;
        end else if (slot_ch != ch_q) begin
          ch_d    = slot_ch;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reloading both fields from one read every cycle keeps them coherent and
  // makes any write to the shown channel visible one cycle after it lands.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      display_name  <= {(NAME_W/8){SPACE_CHAR}};
      display_value <= '0;
    end else if (state_q == ST_FETCH || state_q == ST_SHOW) begin
      display_name  <= rd_name;
      display_value <= rd_value;
    end
  end

  assign display_valid = (state_q == ST_SHOW);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cap_valid <= 1'b0;
      cap_value <= '0;
    end else begin
      cap_valid <= input_valid;
      if (input_valid) cap_value <= touch_value;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lcd_channel_mux.sv
// Directed testbench for lcd_channel_mux with hand-computed expectations.
`default_nettype none

module tb_lcd_channel_mux;

  localparam int NUM_CH = 8;
  localparam int NAME_W = 40;
  localparam int VALUE_W = 32;
  localparam logic [NAME_W-1:0] SPACES = {5{8'h20}};
  localparam logic [NAME_W-1:0] DATA_NAME = {"Data", 8'h20};

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              wr_en = 1'b0;
  logic [2:0]        wr_ch = '0;
  logic              wr_name_en = 1'b0;
  logic [NAME_W-1:0] wr_name = '0;
  logic [31:0]       wr_value = '0;
  logic              cap_en = 1'b0;
  logic [2:0]        cap_ch = '0;
  logic              cap_valid;
  logic [31:0]       cap_value;
  logic [5:0]        display_number = '0;
  logic              input_valid = 1'b0;
  logic [31:0]       input_value = '0;
  logic              display_valid;
  logic [NAME_W-1:0] display_name;
  logic [31:0]       display_value;

  int checks = 0;
  int errors = 0;

  lcd_channel_mux #(
    .NUM_CH(NUM_CH), .BASE_SLOT(1), .NAME_W(NAME_W), .VALUE_W(VALUE_W)
  ) dut (
    .clk(clk), .resetn(resetn),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_name_en(wr_name_en),
    .wr_name(wr_name), .wr_value(wr_value),
    .cap_en(cap_en), .cap_ch(cap_ch),
    .cap_valid(cap_valid), .cap_value(cap_value),
    .display_number(display_number),
    .input_valid(input_valid), .input_value(input_value),
    .display_valid(display_valid), .display_name(display_name),
    .display_value(display_value)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    step();
    checks += 5;
    if (display_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", display_valid); end
    if (display_name !== SPACES) begin errors++; $display("FAIL reset_name got %h want %h", display_name, SPACES); end
    if (display_value !== 32'd0) begin errors++; $display("FAIL reset_value got %h want 0", display_value); end
    if (cap_valid !== 1'b0) begin errors++; $display("FAIL reset_cap_valid got %b want 0", cap_valid); end
    if (cap_value !== 32'd0) begin errors++; $display("FAIL reset_cap_value got %h want 0", cap_value); end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_default_slot();
    display_number = 6'd1;
    step();
    checks++;
    if (display_valid !== 1'b0) begin errors++; $display("FAIL default_fetch_valid got %b want 0", display_valid); end
    step();
    checks += 3;
    if (display_valid !== 1'b1) begin errors++; $display("FAIL default_valid got %b want 1", display_valid); end
    if (display_name !== SPACES) begin errors++; $display("FAIL default_name got %h want %h", display_name, SPACES); end
    if (display_value !== 32'd0) begin errors++; $display("FAIL default_value got %h want 0", display_value); end
  endtask

  task automatic test_write_show();
    wr_en = 1'b1; wr_ch = 3'd2; wr_name_en = 1'b1; wr_name = DATA_NAME; wr_value = 32'd20241106;
    step();
    wr_en = 1'b0; wr_name_en = 1'b0;
    display_number = 6'd3;
    step();
    step();
    checks += 3;
    if (display_valid !== 1'b1) begin errors++; $display("FAIL show_valid got %b want 1", display_valid); end
    if (display_name !== DATA_NAME) begin errors++; $display("FAIL show_name got %h want %h", display_name, DATA_NAME); end
    if (display_value !== 32'd20241106) begin errors++; $display("FAIL show_value got %0d want 20241106", display_value); end
  endtask

  task automatic test_live_update();
    wr_en = 1'b1; wr_ch = 3'd2; wr_name_en = 1'b0; wr_name = {5{8'h41}}; wr_value = 32'hDEADBEEF;
    step();
    wr_en = 1'b0;
    step();
    checks += 3;
    if (display_value !== 32'hDEADBEEF) begin errors++; $display("FAIL live_value got %h want deadbeef", display_value); end
    if (display_name !== DATA_NAME) begin errors++; $display("FAIL live_name got %h want %h", display_name, DATA_NAME); end
    if (display_valid !== 1'b1) begin errors++; $display("FAIL live_valid got %b want 1", display_valid); end
  endtask

  task automatic test_out_of_range();
    display_number = 6'd0;
    step();
    checks++;
    if (display_valid !== 1'b0) begin errors++; $display("FAIL oor_low got %b want 0", display_valid); end
    display_number = 6'd3;
    step();
    step();
    checks++;
    if (display_valid !== 1'b1) begin errors++; $display("FAIL oor_back got %b want 1", display_valid); end
    display_number = 6'(NUM_CH + 1);
    step();
    checks++;
    if (display_valid !== 1'b0) begin errors++; $display("FAIL oor_high got %b want 0", display_valid); end
  endtask

  task automatic test_capture();
    cap_en = 1'b1; cap_ch = 3'd4;
    input_valid = 1'b1; input_value = 32'd1234;
    step();
    input_valid = 1'b0;
    checks += 2;
    if (cap_valid !== 1'b1) begin errors++; $display("FAIL cap_pulse got %b want 1", cap_valid); end
    if (cap_value !== 32'd1234) begin errors++; $display("FAIL cap_value got %0d want 1234", cap_value); end
    step();
    checks++;
    if (cap_valid !== 1'b0) begin errors++; $display("FAIL cap_single got %b want 0", cap_valid); end
    display_number = 6'd5;
    step();
    step();
    checks += 2;
    if (display_valid !== 1'b1) begin errors++; $display("FAIL cap_view_valid got %b want 1", display_valid); end
    if (display_value !== 32'd1234) begin errors++; $display("FAIL cap_view_value got %0d want 1234", display_value); end
  endtask

  task automatic test_collision();
    input_valid = 1'b1; input_value = 32'd555;
    wr_en = 1'b1; wr_ch = 3'd4; wr_name_en = 1'b0; wr_value = 32'd99;
    step();
    input_valid = 1'b0; wr_en = 1'b0;
    checks += 2;
    if (cap_valid !== 1'b1) begin errors++; $display("FAIL coll_cap_valid got %b want 1", cap_valid); end
    if (cap_value !== 32'd555) begin errors++; $display("FAIL coll_cap_value got %0d want 555", cap_value); end
    step();
    checks++;
    if (display_value !== 32'd99) begin errors++; $display("FAIL coll_value got %0d want 99", display_value); end
  endtask

  task automatic test_back_to_back();
    cap_en = 1'b0;
    input_valid = 1'b1; input_value = 32'd7;
    step();
    input_value = 32'd8;
    checks += 2;
    if (cap_valid !== 1'b1) begin errors++; $display("FAIL b2b_first_valid got %b want 1", cap_valid); end
    if (cap_value !== 32'd7) begin errors++; $display("FAIL b2b_first_value got %0d want 7", cap_value); end
    step();
    input_valid = 1'b0;
    checks += 2;
    if (cap_valid !== 1'b1) begin errors++; $display("FAIL b2b_second_valid got %b want 1", cap_valid); end
    if (cap_value !== 32'd8) begin errors++; $display("FAIL b2b_second_value got %0d want 8", cap_value); end
    step();
    checks += 3;
    if (cap_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid got %b want 0", cap_valid); end
    if (cap_value !== 32'd8) begin errors++; $display("FAIL b2b_hold_value got %0d want 8", cap_value); end
    if (display_value !== 32'd99) begin errors++; $display("FAIL b2b_no_write got %0d want 99", display_value); end
  endtask

  task automatic test_fetch_restart();
    display_number = 6'd2;
    step();
    display_number = 6'd3;
    step();
    checks++;
    if (display_valid !== 1'b0) begin errors++; $display("FAIL restart_hidden got %b want 0", display_valid); end
    step();
    checks += 3;
    if (display_valid !== 1'b1) begin errors++; $display("FAIL restart_valid got %b want 1", display_valid); end
    if (display_value !== 32'hDEADBEEF) begin errors++; $display("FAIL restart_value got %h want deadbeef", display_value); end
    if (display_name !== DATA_NAME) begin errors++; $display("FAIL restart_name got %h want %h", display_name, DATA_NAME); end
  endtask

  task automatic test_async_reset();
    #2;
    resetn = 1'b0;
    #1;
    checks += 3;
    if (display_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b want 0", display_valid); end
    if (display_name !== SPACES) begin errors++; $display("FAIL areset_name got %h want %h", display_name, SPACES); end
    if (display_value !== 32'd0) begin errors++; $display("FAIL areset_value got %h want 0", display_value); end
    display_number = 6'd0;
    step();
    resetn = 1'b1;
    step();
    checks++;
    if (display_valid !== 1'b0) begin errors++; $display("FAIL areset_idle got %b want 0", display_valid); end
    display_number = 6'd3;
    step();
    step();
    checks += 3;
    if (display_valid !== 1'b1) begin errors++; $display("FAIL areset_show got %b want 1", display_valid); end
    if (display_value !== 32'd0) begin errors++; $display("FAIL areset_cleared_value got %h want 0", display_value); end
    if (display_name !== SPACES) begin errors++; $display("FAIL areset_cleared_name got %h want %h", display_name, SPACES); end
  endtask

  initial begin
    test_reset();
    test_default_slot();
    test_write_show();
    test_live_update();
    test_out_of_range();
    test_capture();
    test_collision();
    test_back_to_back();
    test_fetch_restart();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lcd_channel_mux.md
# lcd_channel_mux

Parametrised multi-channel feeder for `lcd_module`, replacing the single hard-wired name/value driver in LCD top-levels. It holds `NUM_CH` name/value entries and presents the entry matching the slot number requested by `lcd_module` through `display_number`. It also captures touch-panel input into a selected channel and reports each capture to the host. It sits between system logic (or a CPU register bus) and `lcd_module` in the LCD top-level.

## Interface
- `NUM_CH`, 8: number of display channels, 1..32
- `BASE_SLOT`, 1: `display_number` value mapped to channel 0
- `NAME_W`, 40: name width, a multiple of 8 (ASCII, MSB = first character)
- `VALUE_W`, 32: value width
- `clk` in 1: system clock
- `resetn` in 1: reset, asynchronous and active-low
- `wr_en` in 1: host write strobe, one cycle
- `wr_ch` in $clog2(NUM_CH): host write channel
- `wr_name_en` in 1: with `wr_en`, also write the name; otherwise write the value only
- `wr_name` in NAME_W: name to write
- `wr_value` in VALUE_W: value to write
- `cap_en` in 1: allow touch input to overwrite a channel value
- `cap_ch` in $clog2(NUM_CH): channel that receives touch input
- `cap_valid` out 1: one-cycle pulse, a touch value was captured
- `cap_value` out VALUE_W: last captured touch value
- `display_number` in 6: slot requested by `lcd_module`
- `input_valid` in 1: touch value strobe from `lcd_module`
- `input_value` in 32: touch value from `lcd_module`
- `display_valid` out 1: `display_name` and `display_value` are valid for the current slot
- `display_name` out NAME_W: name for the current slot
- `display_value` out VALUE_W: value for the current slot

## Operation
- Storage is a register file of `NUM_CH` name/value pairs.
  - On reset, every name byte is 8'h20 (space) and every value is 0.
- Slot mapping: `display_number` maps to channel `ch = display_number - BASE_SLOT` when BASE_SLOT ≤ `display_number` < BASE_SLOT+NUM_CH. Any other `display_number` is out of range.
- The FSM has three states: IDLE, FETCH, SHOW.
  - IDLE: `display_valid`=0. When `display_number` is in range, latch `ch` and go to FETCH.
  - FETCH: register the entry for `ch` into the output registers, then go to SHOW.
  - SHOW: `display_valid`=1 and the outputs are held.
    - If `display_number` changes to another in-range slot, go to FETCH.
    - If it goes out of range, go to IDLE; `display_valid` drops the next cycle.
- Host write:
  - `wr_en` updates entry `wr_ch` on the next edge.
  - A `wr_ch` ≥ NUM_CH is ignored.
  - The name is written only when `wr_name_en`=1.
- Live update: in SHOW, a write that hits the shown channel reloads both output registers together on the cycle after the write. Name and value never mix old and new contents.
- Touch capture:
  - On `input_valid`, the block registers `input_value` into `cap_value` and pulses `cap_valid` one cycle later.
  - If `cap_en`=1, the value is also written into entry `cap_ch`.
  - `input_value` is truncated or zero-extended to VALUE_W.
- Simultaneous host write and touch capture to the same channel: the host write wins the value field. `cap_valid` and `cap_value` still report the touch value.

## Timing
- Output reset values: `display_valid`=0, `display_name`= all spaces, `display_value`=0, `cap_valid`=0, `cap_value`=0.
- Slot change to first `display_valid` takes 2 cycles (sample, FETCH).
- Write to visible change on a shown channel takes 1 cycle.
- `display_number` is sampled every cycle. A change during FETCH restarts FETCH with the new slot, and no stale data is presented.
- Reset asserted mid-operation:
  - Asynchronously clears all outputs, the register file and the FSM to IDLE.
  - After deassertion, nothing is presented until the next in-range `display_number` is seen.
- Back-to-back `input_valid` pulses each produce their own `cap_valid` pulse. The latest value wins.

## Structure
- Shared `lcd_pkg`:
  - FSM state encoding
  - the space-character constant (8'h20)
  - the `display_number` width (6)
- One sub-module, `lcd_chan_regfile`:
  - `NUM_CH`-entry name/value storage
  - two write ports (host and capture), with fixed priority host > capture
  - one combinational read port
- The FSM and the capture logic live in the top of this block.

## Test plan
- Reset, then `display_number`=1 with defaults: after 2 cycles `display_valid`=1, name "     ", value 0.
- Write ch2 with name "Data", value 32'd20241106, then set `display_number`=3: after 2 cycles the outputs show "Data" and 20241106.
- While showing ch2, write the value only (32'hDEAD_BEEF): one cycle later `display_value`=32'hDEADBEEF and the name is unchanged.
- Set `display_number`=0, then `display_number`=NUM_CH+1: `display_valid`=0 in both cases, one cycle after each change.
- `cap_en`=1, `cap_ch`=4, `input_valid` with 32'd1234: `cap_valid` pulses once with `cap_value`=1234, and a subsequent view of slot 5 shows 1234. In the same cycle as a second capture, issue a host write of 99 to ch4: ch4 holds 99.
- Assert `resetn` low while in SHOW: all outputs are at their reset values before the next clock edge.
